cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//  Consumes the slow square wave from the clock divider; drives the 8-bit CPU's clock-enable.
//  Turns each rising edge of that wave into a one-CLK-cycle cpuEn pulse.
//  Run/pause and single-step come from board push-buttons. A HLT from the CPU freezes it.
//  Sits between the clock divider and the CPU core; all logic runs on the 10 MHz CLK.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd10000  CLK cycles a button level must be stable to be accepted (1 ms @10 MHz)
//  CNT_WIDTH        16         width of cycleCount
// PORTS
//  CLK         in   1          system clock, 10 MHz
//  RST         in   1          asynchronous, active-high reset
//  tickIn      in   1          divided clock from divider (CLK-domain register, no sync needed)
//  fastMode    in   1          1: treat every CLK cycle as a tick (bypass divider)
//  runBtn      in   1          raw push-button, active-high, asynchronous
//  stepBtn     in   1          raw push-button, active-high, asynchronous
//  haltReq     in   1          CPU executed HLT, level, CLK domain
//  cpuEn       out  1          registered single-cycle CPU enable pulse
//  running     out  1          1 while state == RUN
//  halted      out  1          1 while state == HALT
//  cycleCount  out  CNT_WIDTH  number of cpuEn pulses issued since reset
// BEHAVIOUR
//  Reset: async, active-high, immediate, including mid-pulse or mid-debounce.
//   - Outputs: cpuEn=0, running=0, halted=0, cycleCount=0.
//   - Internal: state=IDLE, sync/edge/debounce regs=0.
//  Buttons:
//   - 2-FF synchronizer per button.
//   - Press = rising edge of the accepted level, giving a runPress/stepPress pulse of one cycle.
//  Tick: tickEdge = (tickIn & ~tickPrev) when fastMode=0; tickEdge = 1 every cycle when fastMode=1.
//  FSM (registered state; priority per state top to bottom):
//   IDLE: haltReq->HALT; runPress->RUN; stepPress->STEP; else stay.
//   RUN:  haltReq->HALT; runPress->IDLE (no pulse this cycle); tickEdge->cpuEn pulse, stay.
//   STEP: haltReq->HALT; tickEdge->cpuEn pulse, ->IDLE.
//   HALT: runPress->IDLE (clears halt; haltReq ignored that cycle); else stay. stepBtn ignored.
//  Latency and pulse rules:
//   - cpuEn rises on the CLK edge after the tickEdge cycle and is high for exactly 1 cycle.
//   - At most one pulse per tickEdge.
//  Simultaneous events:
//   - haltReq beats any button.
//   - runPress beats stepPress.
//   - A state exit beats tickEdge: no pulse on the exit cycle.
//  Step timing: a step waits for the next tickEdge, up to 1 s at 1 Hz. In fastMode=1 the pulse follows the next cycle.
//  cycleCount: +1 on every cpuEn pulse, modulo 2^CNT_WIDTH (0xFFFF -> 0x0000).
//  fastMode may change at any time; it takes effect on the next cycle's tickEdge.
// CONFIGURATION
//  CPU_CLKCTL_DEBOUNCE_EN defined:
//   - Each synchronized button feeds a counter; the accepted level changes only when the raw level differs from it.
//   - The raw level must then stay stable for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
//   - Press latency from the synchronizer output = DEBOUNCE_CYCLES + 1 cycles.
//  Not defined: accepted level = synchronizer output. Press latency = 3 cycles from the raw edge.
//   - No debounce counters are synthesized. DEBOUNCE_CYCLES is unused.
// TESTING
//  1 Reset, fastMode=1, runBtn press
//     -> running=1; cpuEn high every cycle; cycleCount counts 1,2,3...
//  2 fastMode=0, tickIn period 20 cycles, in RUN
//     -> one cpuEn per tickIn rise, 1 cycle after it; cycleCount +1 per rise.
//  3 IDLE, stepBtn press, tickIn period 20
//     -> exactly one cpuEn; back to IDLE; cycleCount=1; no further pulses.
//  4 RUN, haltReq=1 on the same cycle as tickEdge
//     -> no pulse; halted=1, running=0.
//     -> Then stepBtn ignored; runBtn returns to IDLE with halted=0.
//  5 Preload cycleCount to 0xFFFF (force), one pulse
//     -> cycleCount=0x0000.
//     -> RST asserted mid-RUN: all outputs 0 immediately, no pulse on release.
//  6 With CPU_CLKCTL_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: runBtn bounce 3 on / 2 off / 12 on
//     -> a single runPress, 8+1 cycles after the final rise.
//     -> Without the macro: multiple presses (RUN/IDLE toggles).

Source files
------------

// File: rtl/cpu_clock_controller.sv
// cpu_clock_controller
// Turns rising edges of the divided clock (or every cycle in fast mode) into
// single-cycle CPU clock-enable pulses, gated by a run/step/halt state machine
// driven from two push-buttons and the CPU's HLT request.
// Optional button debouncing is compiled in with CPU_CLKCTL_DEBOUNCE_EN.
//
// Handshake: there is no valid/ready pair here; cpuEn is a one-cycle strobe
// that the CPU consumes unconditionally on the cycle it is high.
module cpu_clock_controller #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd10000,
  parameter int          CNT_WIDTH       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 tickIn,
  input  logic                 fastMode,
  input  logic                 runBtn,
  input  logic                 stepBtn,
  input  logic                 haltReq,
  output logic                 cpuEn,
  output logic                 running,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] cycleCount,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   cpu_en_q;
  logic                   running_q;
  logic                   halted_q;
  logic [CNT_WIDTH-1:0]   count_q;

  logic [1:0]             run_sync_q;
  logic [1:0]             step_sync_q;
  logic                   run_sync;
  logic                   step_sync;
  logic                   run_lvl;
  logic                   step_lvl;
  logic                   run_lvl_prev_q;
  logic                   step_lvl_prev_q;
  logic                   run_press;
  logic                   step_press;

  logic                   tick_prev_q;
  logic                   tick_edge;

  assign run_sync  = run_sync_q[1];
  assign step_sync = step_sync_q[1];

  // Two-flop synchronizers for the asynchronous push-buttons
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_sync_q  <= 2'b00;
      step_sync_q <= 2'b00;
    end else begin
      run_sync_q  <= {run_sync_q[0], runBtn};
      step_sync_q <= {step_sync_q[0], stepBtn};
    end
  end

`ifdef CPU_CLKCTL_DEBOUNCE_EN
  logic [15:0] run_cnt_q;
  logic [15:0] run_cnt_d;
  logic [15:0] step_cnt_q;
  logic [15:0] step_cnt_d;
  logic        run_lvl_q;
  logic        run_lvl_d;
  logic        step_lvl_q;
  logic        step_lvl_d;

  // Accepted level follows the synchronized level only after it has differed
  // for DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_comb begin
    run_cnt_d  = 16'd0;
    run_lvl_d  = run_lvl_q;
    step_cnt_d = 16'd0;
    step_lvl_d = step_lvl_q;
    if (run_sync != run_lvl_q) begin
      if (run_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        run_lvl_d = run_sync;
      end else begin
        run_cnt_d = run_cnt_q + 16'd1;
      end
    end
    if (step_sync != step_lvl_q) begin
      if (step_cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        step_lvl_d = step_sync;
      end else begin
        step_cnt_d = step_cnt_q + 16'd1;
      end
    end
  end

  // Debounce counter and accepted-level registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_cnt_q  <= 16'd0;
      run_lvl_q  <= 1'b0;
      step_cnt_q <= 16'd0;
      step_lvl_q <= 1'b0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      run_lvl_q  <= run_lvl_d;
      step_cnt_q <= step_cnt_d;
      step_lvl_q <= step_lvl_d;
    end
  end

  assign run_lvl  = run_lvl_q;
  assign step_lvl = step_lvl_q;
`else
  // Without debouncing the synchronized level is taken as-is
  assign run_lvl  = run_sync;
  assign step_lvl = step_sync;

  // DEBOUNCE_CYCLES has no effect in this build; referenced here only so the
  // parameter stays part of the interface in both builds.
  if (DEBOUNCE_CYCLES == 16'd0) begin : g_debounce_length_ignored
  end
`endif

  // Previous accepted levels for rising-edge press detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_lvl_prev_q  <= 1'b0;
      step_lvl_prev_q <= 1'b0;
    end else begin
      run_lvl_prev_q  <= run_lvl;
      step_lvl_prev_q <= step_lvl;
    end
  end

  assign run_press  = run_lvl & ~run_lvl_prev_q;
  assign step_press = step_lvl & ~step_lvl_prev_q;

  // Previous divided-clock level for tick edge detection
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tick_prev_q <= 1'b0;
    end else begin
      tick_prev_q <= tickIn;
    end
  end

  // Fast mode bypasses the divider: every cycle is a tick
  assign tick_edge = fastMode | (tickIn & ~tick_prev_q);

  // Run/step/halt state machine with registered enable, flags and pulse counter.
  // Within each state the checks run in priority order; leaving a state
  // always suppresses the pulse on that cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      cpu_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (haltReq) begin
            state_q   <= ST_HALT;
            halted_q  <= 1'b1;
            running_q <= 1'b0;
          end else if (run_press) begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end else if (step_press) begin
            state_q <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (haltReq) begin
            state_q   <= ST_HALT;
            halted_q  <= 1'b1;
            running_q <= 1'b0;
          end else if (run_press) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end else if (tick_edge) begin
            cpu_en_q <= 1'b1;
            count_q  <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
        ST_STEP: begin
          if (haltReq) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (tick_edge) begin
            cpu_en_q <= 1'b1;
            count_q  <= count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            state_q  <= ST_IDLE;
          end
        end
        ST_HALT: begin
          // Only a run press leaves HALT; haltReq is ignored on that cycle
          if (run_press) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          running_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cpuEn      = cpu_en_q;
  assign running    = running_q;
  assign halted     = halted_q;
  assign cycleCount = count_q;
  assign dbgState   = state_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Bench for cpu_clock_controller: table-driven vectors, hand sequences for
// multi-cycle corners, randomized stimulus against a cycle-level reference
// model derived from the behavioural rules, and a full counter wrap.
module tb_cpu_clock_controller;

  localparam int DB = 8;
  localparam int CW = 16;
  localparam int HL = DB + 4;
`ifdef CPU_CLKCTL_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic          CLK;
  logic          RST;
  logic          tickIn;
  logic          fastMode;
  logic          runBtn;
  logic          stepBtn;
  logic          haltReq;
  logic          cpuEn;
  logic          running;
  logic          halted;
  logic [CW-1:0] cycleCount;
  logic [1:0]    dbgState;

  cpu_clock_controller #(
    .DEBOUNCE_CYCLES(16'(DB)),
    .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .tickIn(tickIn),
    .fastMode(fastMode),
    .runBtn(runBtn),
    .stepBtn(stepBtn),
    .haltReq(haltReq),
    .cpuEn(cpuEn),
    .running(running),
    .halted(halted),
    .cycleCount(cycleCount),
    .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes of the controller as seen from outside
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;
  localparam int M_HALT = 3;

  int            m_mode;
  bit            m_en;
  logic [CW-1:0] m_cnt;
  bit            m_tick_prev;
  bit [HL-1:0]   m_run_hist;   // bit j = raw run button j cycles ago
  bit [HL-1:0]   m_step_hist;
  bit            m_run_acc;
  bit            m_step_acc;
  bit            tick_auto;
  int            tick_phase;

  // Accepted button level this cycle: raw level two cycles late (synchronizer);
  // with debouncing it changes only once the synchronized level has held a
  // new value for DB consecutive cycles.
  function automatic bit next_acc(input bit [HL-1:0] h, input bit acc_prev);
    bit v;
    if (!DB_EN) return h[2];
    v = h[3];
    for (int i = 1; i <= DB; i++) begin
      if (h[2+i] != v) return acc_prev;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_en        = 1'b0;
    m_cnt       = '0;
    m_tick_prev = 1'b0;
    m_run_hist  = '0;
    m_step_hist = '0;
    m_run_acc   = 1'b0;
    m_step_acc  = 1'b0;
  endtask

  // One clock cycle: advance the model on the current inputs, clock the DUT,
  // compare all outputs shortly after the edge.
  task automatic cycle();
    bit ra, sa, rp, sp, te;
    if (tick_auto) begin
      tickIn = ((tick_phase / 10) % 2) != 0;
      tick_phase++;
    end
    m_run_hist  = {m_run_hist[HL-2:0], runBtn};
    m_step_hist = {m_step_hist[HL-2:0], stepBtn};
    ra = next_acc(m_run_hist, m_run_acc);
    sa = next_acc(m_step_hist, m_step_acc);
    rp = ra & ~m_run_acc;
    sp = sa & ~m_step_acc;
    m_run_acc  = ra;
    m_step_acc = sa;
    te = fastMode | (tickIn & ~m_tick_prev);
    m_tick_prev = tickIn;
    m_en = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (haltReq) m_mode = M_HALT;
        else if (rp) m_mode = M_RUN;
        else if (sp) m_mode = M_STEP;
      end
      M_RUN: begin
        if (haltReq) m_mode = M_HALT;
        else if (rp) m_mode = M_IDLE;
        else if (te) m_en = 1'b1;
      end
      M_STEP: begin
        if (haltReq) m_mode = M_HALT;
        else if (te) begin
          m_en   = 1'b1;
          m_mode = M_IDLE;
        end
      end
      default: begin
        if (rp) m_mode = M_IDLE;
      end
    endcase
    if (m_en) m_cnt = m_cnt + 1'b1;
    @(posedge CLK);
    #1;
    check("cpuEn", 32'(cpuEn), 32'(m_en));
    check("running", 32'(running), 32'(m_mode == M_RUN));
    check("halted", 32'(halted), 32'(m_mode == M_HALT));
    check("cycleCount", 32'(cycleCount), 32'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    RST = 1'b1;
    fastMode = 1'b0;
    tickIn = 1'b0;
    runBtn = 1'b0;
    stepBtn = 1'b0;
    haltReq = 1'b0;
    tick_auto = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_cpuEn", 32'(cpuEn), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cycleCount", 32'(cycleCount), 32'd0);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic press(input bit is_run, input int hold);
    if (is_run) runBtn = 1'b1; else stepBtn = 1'b1;
    repeat (hold) cycle();
    if (is_run) runBtn = 1'b0; else stepBtn = 1'b0;
    repeat (hold) cycle();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic fast;
    logic tick;
    logic halt;
    logic en;
    logic run;
    logic hlt;
    int   cnt_inc;
  } vec_t;

  vec_t tbl[11];

  localparam int T1_PULSES = 24 - 3 - (DB_EN ? DB : 0);

  initial begin
    int run_hold;
    int step_hold;
    int halt_hold;
    int guard;
    int transitions;
    logic prev_running;
    logic [CW-1:0] base;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3};

    tick_phase = 0;
    do_reset();

    // Fast mode run: a pulse on every cycle once RUN is entered
    fastMode = 1'b1;
    press(1'b1, 12);
    check("t1_count", 32'(cycleCount), 32'(T1_PULSES));

    // Divided clock, period 20: one pulse per rise
    fastMode = 1'b0;
    tick_auto = 1'b1;
    tick_phase = 0;
    repeat (100) cycle();
    check("t2_count", 32'(cycleCount), 32'(T1_PULSES + 5));

    // Table: tick/fast/halt interplay starting in RUN
    tick_auto = 1'b0;
    tickIn = 1'b0;
    cycle();
    base = CW'(T1_PULSES + 5);
    for (int i = 0; i < 11; i++) begin
      fastMode = tbl[i].fast;
      tickIn   = tbl[i].tick;
      haltReq  = tbl[i].halt;
      cycle();
      check($sformatf("tbl%0d_cpuEn", i), 32'(cpuEn), 32'(tbl[i].en));
      check($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].run));
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].hlt));
      check($sformatf("tbl%0d_count", i), 32'(cycleCount), 32'(base + CW'(tbl[i].cnt_inc)));
    end
    fastMode = 1'b0;
    tickIn = 1'b0;
    haltReq = 1'b0;

    // In HALT: step ignored, run returns to IDLE
    press(1'b0, 12);
    check("halt_step_ignored", 32'(halted), 32'd1);
    press(1'b1, 12);
    check("halt_cleared", 32'(halted), 32'd0);
    check("halt_to_idle", 32'(running), 32'd0);

    // Single step from IDLE waits for the next tick rise
    do_reset();
    tick_auto = 1'b1;
    tick_phase = 0;
    press(1'b0, 12);
    repeat (60) cycle();
    check("step_count", 32'(cycleCount), 32'd1);
    check("step_idle_running", 32'(running), 32'd0);
    check("step_idle_halted", 32'(halted), 32'd0);

    // Asynchronous reset in the middle of RUN
    do_reset();
    fastMode = 1'b1;
    press(1'b1, 12);
    repeat (5) cycle();
    RST = 1'b1;
    #2;
    check("arst_cpuEn", 32'(cpuEn), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    check("arst_halted", 32'(halted), 32'd0);
    check("arst_count", 32'(cycleCount), 32'd0);
    fastMode = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    fastMode = 1'b1;
    repeat (5) cycle();
    check("arst_release_cpuEn", 32'(cpuEn), 32'd0);
    check("arst_release_count", 32'(cycleCount), 32'd0);

    // Bouncing run button: 3 on / 2 off / 12 on
    do_reset();
    transitions = 0;
    prev_running = 1'b0;
    for (int i = 0; i < 37; i++) begin
      runBtn = (i < 3) || (i >= 5 && i < 17);
      cycle();
      if (running !== prev_running) transitions++;
      prev_running = running;
    end
    check("bounce_transitions", 32'(transitions), DB_EN ? 32'd1 : 32'd2);
    check("bounce_running", 32'(running), DB_EN ? 32'd1 : 32'd0);

    // Randomized stimulus against the model
    do_reset();
    run_hold = 0;
    step_hold = 0;
    halt_hold = 0;
    for (int i = 0; i < 1200; i++) begin
      fastMode = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) tickIn = ~tickIn;
      if (halt_hold > 0) begin
        halt_hold--;
      end else begin
        haltReq = ($urandom_range(0, 59) == 0);
        halt_hold = haltReq ? $urandom_range(0, 2) : 0;
      end
      if (run_hold > 0) begin
        run_hold--;
      end else if (runBtn) begin
        runBtn = 1'b0;
        run_hold = $urandom_range(2, DB + 20);
      end else if ($urandom_range(0, 5) == 0) begin
        runBtn = 1'b1;
        run_hold = $urandom_range(1, DB + 10);
      end
      if (step_hold > 0) begin
        step_hold--;
      end else if (stepBtn) begin
        stepBtn = 1'b0;
        step_hold = $urandom_range(2, DB + 20);
      end else if ($urandom_range(0, 5) == 0) begin
        stepBtn = 1'b1;
        step_hold = $urandom_range(1, DB + 10);
      end
      cycle();
    end

    // Counter wrap 0xFFFF -> 0x0000
    do_reset();
    fastMode = 1'b1;
    press(1'b1, 12);
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cycle();
      guard++;
    end
    if (m_cnt != 16'hFFFF) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_reach: cycle budget %0d expired at count %0h", guard, cycleCount);
    end else begin
      check("wrap_ffff", 32'(cycleCount), 32'h0000FFFF);
      cycle();
      check("wrap_zero", 32'(cycleCount), 32'd0);
      check("wrap_cpuEn", 32'(cpuEn), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
